// File: rtl/branch_predictor.sv
// Direct-mapped BTB plus 2-bit counter table, bimodal or gshare indexed.
// Predictions are registered one cycle after a lookup; updates are non-speculative.
module branch_predictor #(
  parameter int PC_W    = 64,
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 8,
  parameter int MODE    = 0,
  parameter int HIST_W  = 6
) (
  input  logic            clk,
  input  logic            arst,
  input  logic            en,
  input  logic            flush,
  input  logic            lk_valid,
  input  logic [PC_W-1:0] lk_pc,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic [PC_W-1:0] upd_target,
  input  logic            upd_taken,
  input  logic            upd_jump,
  output logic            pred_valid,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0] btb_valid;
  logic [ENTRIES-1:0] btb_jump;
  logic [TAG_W-1:0]   btb_tag    [ENTRIES];
  logic [PC_W-1:0]    btb_target [ENTRIES];
  logic [1:0]         ctr        [ENTRIES];
  logic [HIST_W-1:0]  ghr;

  logic [IDX_W-1:0] ghr_ext;
  logic [IDX_W-1:0] lk_idx, lk_cidx, upd_idx, upd_cidx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             lk_hit, lk_taken;
  logic [PC_W-1:0]  lk_next;
  logic [1:0]       ctr_next;
  logic             btb_wr;
  logic             state_upd;

  assign ghr_ext = (MODE == 1) ? IDX_W'(ghr) : '0;

  always_comb begin
    lk_idx   = lk_pc[IDX_W+1:2];
    lk_tag   = lk_pc[IDX_W+TAG_W+1:IDX_W+2];
    lk_cidx  = lk_idx ^ ghr_ext;
    upd_idx  = upd_pc[IDX_W+1:2];
    upd_tag  = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
    upd_cidx = upd_idx ^ ghr_ext;
    lk_hit   = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag);
    lk_taken = lk_hit && (ctr[lk_cidx][1] || btb_jump[lk_idx]);
    lk_next  = lk_taken ? btb_target[lk_idx] : lk_pc + PC_W'(4);
  end

  always_comb begin
    ctr_next = ctr[upd_cidx];
    if (upd_jump)
      ctr_next = 2'b11;
    else if (upd_taken)
      ctr_next = (ctr[upd_cidx] == 2'b11) ? 2'b11 : ctr[upd_cidx] + 2'b01;
    else
      ctr_next = (ctr[upd_cidx] == 2'b00) ? 2'b00 : ctr[upd_cidx] - 2'b01;
  end

  // flush outranks updates and lookups; en=0 freezes everything
  assign state_upd = en && !flush && upd_valid;
  assign btb_wr    = state_upd && (upd_taken || upd_jump);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      btb_valid   <= '0;
      ghr         <= '0;
      pred_valid  <= 1'b0;
      pred_hit    <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= 2'b01;
    end else if (en) begin
      if (flush) begin
        btb_valid  <= '0;
        ghr        <= '0;
        pred_valid <= 1'b0;
        for (int i = 0; i < ENTRIES; i++) ctr[i] <= 2'b01;
      end else begin
        pred_valid <= lk_valid;
        if (lk_valid) begin
          pred_hit    <= lk_hit;
          pred_taken  <= lk_taken;
          pred_target <= lk_next;
        end
        if (upd_valid) begin
          ctr[upd_cidx] <= ctr_next;
          if (MODE == 1) ghr <= (ghr << 1) | HIST_W'(upd_taken | upd_jump);
        end
        if (btb_wr) btb_valid[upd_idx] <= 1'b1;
      end
    end
  end

  // payload fields are only meaningful behind a valid bit, so they carry no reset
  always_ff @(posedge clk) begin
    if (btb_wr) begin
      btb_tag[upd_idx]    <= upd_tag;
      btb_target[upd_idx] <= upd_target;
      btb_jump[upd_idx]   <= upd_jump;
    end
  end

  logic unused_upd_pc;
  assign unused_upd_pc = ^upd_pc;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: a bimodal and a gshare instance share stimulus
// and are compared against an array-based reference model.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        arst = 1'b1, en = 1'b0, flush = 1'b0, lk_valid = 1'b0;
  logic        upd_valid = 1'b0, upd_taken = 1'b0, upd_jump = 1'b0;
  logic [63:0] lk_pc = '0, upd_pc = '0, upd_target = '0;
  logic [1:0]  pv, ph, pt;
  logic [63:0] ptg0, ptg1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  branch_predictor #(.PC_W(64), .ENTRIES(16), .TAG_W(8), .MODE(0), .HIST_W(4)) u_bim (
    .clk(clk), .arst(arst), .en(en), .flush(flush), .lk_valid(lk_valid), .lk_pc(lk_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
    .upd_jump(upd_jump), .pred_valid(pv[0]), .pred_hit(ph[0]), .pred_taken(pt[0]),
    .pred_target(ptg0));

  branch_predictor #(.PC_W(64), .ENTRIES(16), .TAG_W(8), .MODE(1), .HIST_W(4)) u_gsh (
    .clk(clk), .arst(arst), .en(en), .flush(flush), .lk_valid(lk_valid), .lk_pc(lk_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
    .upd_jump(upd_jump), .pred_valid(pv[1]), .pred_hit(ph[1]), .pred_taken(pt[1]),
    .pred_target(ptg1));

  // reference model: [0] bimodal, [1] gshare with 4-bit history
  bit          m_valid [2][16];
  int          m_tag   [2][16];
  logic [63:0] m_tgt   [2][16];
  bit          m_jmp   [2][16];
  int          m_ctr   [2][16];
  int          m_ghr   [2];
  bit          m_pv [2], m_ph [2], m_pt [2];
  logic [63:0] m_ptg [2];

  task automatic m_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 16; i++) begin
        m_valid[m][i] = 0;
        m_ctr[m][i]   = 1;
      end
      m_ghr[m] = 0;
      m_pv[m] = 0; m_ph[m] = 0; m_pt[m] = 0; m_ptg[m] = '0;
    end
  endtask

  task automatic m_step();
    for (int m = 0; m < 2; m++) begin
      int li, lc, ui, uc;
      bit hit;
      if (!en) continue;
      if (flush) begin
        for (int i = 0; i < 16; i++) begin
          m_valid[m][i] = 0;
          m_ctr[m][i]   = 1;
        end
        m_ghr[m] = 0;
        m_pv[m]  = 0;
        continue;
      end
      m_pv[m] = lk_valid;
      if (lk_valid) begin
        li  = int'((lk_pc >> 2) % 16);
        lc  = (m == 1) ? (li ^ m_ghr[m]) : li;
        hit = m_valid[m][li] && (m_tag[m][li] == int'((lk_pc >> 6) % 256));
        m_ph[m]  = hit;
        m_pt[m]  = hit && (m_ctr[m][lc] >= 2 || m_jmp[m][li]);
        m_ptg[m] = m_pt[m] ? m_tgt[m][li] : lk_pc + 64'd4;
      end
      if (upd_valid) begin
        ui = int'((upd_pc >> 2) % 16);
        uc = (m == 1) ? (ui ^ m_ghr[m]) : ui;
        if (upd_jump)       m_ctr[m][uc] = 3;
        else if (upd_taken) m_ctr[m][uc] = (m_ctr[m][uc] == 3) ? 3 : m_ctr[m][uc] + 1;
        else                m_ctr[m][uc] = (m_ctr[m][uc] == 0) ? 0 : m_ctr[m][uc] - 1;
        if (upd_taken || upd_jump) begin
          m_valid[m][ui] = 1;
          m_tag[m][ui]   = int'((upd_pc >> 6) % 256);
          m_tgt[m][ui]   = upd_target;
          m_jmp[m][ui]   = upd_jump;
        end
        if (m == 1) m_ghr[m] = ((m_ghr[m] << 1) | int'(upd_taken | upd_jump)) % 16;
      end
    end
  endtask

  task automatic cycle(input bit e, input bit f, input bit lv, input logic [63:0] lpc,
                       input bit uv, input logic [63:0] upc, input logic [63:0] utgt,
                       input bit ut, input bit uj);
    en = e; flush = f; lk_valid = lv; lk_pc = lpc;
    upd_valid = uv; upd_pc = upc; upd_target = utgt; upd_taken = ut; upd_jump = uj;
    @(posedge clk);
    m_step();
    #1;
    en = 1'b1; flush = 1'b0; lk_valid = 1'b0; upd_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic lk(input logic [63:0] pc);
    cycle(1, 0, 1, pc, 0, '0, '0, 0, 0);
  endtask

  task automatic up(input logic [63:0] pc, input logic [63:0] tgt, input bit t, input bit j);
    cycle(1, 0, 0, '0, 1, pc, tgt, t, j);
  endtask

  task automatic do_reset();
    arst = 1'b1;
    m_reset();
    @(negedge clk);
    @(negedge clk);
    arst = 1'b0;
    en = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (pv !== 2'b00) begin n_bad++; $display("FAIL reset_valid got %b want 00", pv); end
    n_cmp++; if (ph !== 2'b00 || pt !== 2'b00) begin n_bad++; $display("FAIL reset_hit_taken got %b/%b want 00/00", ph, pt); end
    n_cmp++; if (ptg0 !== 64'h0 || ptg1 !== 64'h0) begin n_bad++; $display("FAIL reset_target got %h/%h want 0", ptg0, ptg1); end
    lk(64'h100);
    n_cmp++; if (pv[0] !== 1'b1) begin n_bad++; $display("FAIL cold_valid got %b want 1", pv[0]); end
    n_cmp++; if (ph[0] !== 1'b0 || pt[0] !== 1'b0) begin n_bad++; $display("FAIL cold_hit_taken got %b/%b want 0/0", ph[0], pt[0]); end
    n_cmp++; if (ptg0 !== 64'h104) begin n_bad++; $display("FAIL cold_target got %h want 104", ptg0); end
  endtask

  task automatic test_taken_update();
    up(64'h100, 64'h200, 1, 0);
    lk(64'h100);
    n_cmp++; if (ph[0] !== 1'b1 || pt[0] !== 1'b1) begin n_bad++; $display("FAIL taken_hit_taken got %b/%b want 1/1", ph[0], pt[0]); end
    n_cmp++; if (ptg0 !== 64'h200) begin n_bad++; $display("FAIL taken_target got %h want 200", ptg0); end
  endtask

  task automatic test_enable_hold();
    cycle(0, 1, 1, 64'h500, 1, 64'h100, 64'h999, 0, 1);
    n_cmp++; if (pv[0] !== 1'b1 || ph[0] !== 1'b1 || ptg0 !== 64'h200) begin
      n_bad++; $display("FAIL en_freeze got v=%b h=%b t=%h want 1/1/200", pv[0], ph[0], ptg0); end
    cycle(1, 0, 0, 64'h700, 0, '0, '0, 0, 0);
    n_cmp++; if (pv[0] !== 1'b0 || ptg0 !== 64'h200 || pt[0] !== 1'b1) begin
      n_bad++; $display("FAIL idle_hold got v=%b tk=%b t=%h want 0/1/200", pv[0], pt[0], ptg0); end
    lk(64'h100);
    n_cmp++; if (pt[0] !== 1'b1 || ptg0 !== 64'h200) begin n_bad++; $display("FAIL en_state_kept got %b/%h want 1/200", pt[0], ptg0); end
  endtask

  task automatic test_counter_sat();
    up(64'h100, 64'h200, 1, 0);
    up(64'h100, 64'h200, 1, 0);
    up(64'h100, 64'h200, 0, 0);
    up(64'h100, 64'h200, 0, 0);
    lk(64'h100);
    n_cmp++; if (ph[0] !== 1'b1 || pt[0] !== 1'b0) begin n_bad++; $display("FAIL ctr_sat_hit_taken got %b/%b want 1/0", ph[0], pt[0]); end
    n_cmp++; if (ptg0 !== 64'h104) begin n_bad++; $display("FAIL ctr_sat_target got %h want 104", ptg0); end
  endtask

  task automatic test_alias();
    up(64'h140, 64'h300, 1, 0);
    lk(64'h100);
    n_cmp++; if (ph[0] !== 1'b0 || ptg0 !== 64'h104) begin n_bad++; $display("FAIL alias_old got h=%b t=%h want 0/104", ph[0], ptg0); end
    lk(64'h140);
    n_cmp++; if (ph[0] !== 1'b1 || ptg0 !== 64'h300) begin n_bad++; $display("FAIL alias_new got h=%b t=%h want 1/300", ph[0], ptg0); end
  endtask

  task automatic test_jump_flush();
    up(64'h80, 64'h400, 0, 1);
    lk(64'h80);
    n_cmp++; if (pt[0] !== 1'b1 || ptg0 !== 64'h400) begin n_bad++; $display("FAIL jump got tk=%b t=%h want 1/400", pt[0], ptg0); end
    cycle(1, 1, 1, 64'h80, 1, 64'h80, 64'h500, 1, 0);
    n_cmp++; if (pv !== 2'b00) begin n_bad++; $display("FAIL flush_valid got %b want 00", pv); end
    lk(64'h80);
    n_cmp++; if (ph[0] !== 1'b0 || pt[0] !== 1'b0 || ptg0 !== 64'h84) begin
      n_bad++; $display("FAIL flush_miss got h=%b tk=%b t=%h want 0/0/84", ph[0], pt[0], ptg0); end
  endtask

  task automatic test_gshare();
    do_reset();
    for (int i = 0; i < 4; i++) up(64'h100, 64'h200, 1, 0);
    lk(64'h100);
    n_cmp++; if (ph[1] !== 1'b1 || pt[1] !== 1'b0 || ptg1 !== 64'h104) begin
      n_bad++; $display("FAIL gshare_idx_f got h=%b tk=%b t=%h want 1/0/104", ph[1], pt[1], ptg1); end
    n_cmp++; if (pt[0] !== 1'b1 || ptg0 !== 64'h200) begin n_bad++; $display("FAIL bimodal_ref got %b/%h want 1/200", pt[0], ptg0); end
    up(64'h100, 64'h200, 1, 0);
    lk(64'h100);
    n_cmp++; if (pt[1] !== 1'b1 || ptg1 !== 64'h200) begin n_bad++; $display("FAIL gshare_trained got %b/%h want 1/200", pt[1], ptg1); end
  endtask

  task automatic test_async_reset();
    lk(64'h100);
    n_cmp++; if (pv !== 2'b11) begin n_bad++; $display("FAIL pre_arst_valid got %b want 11", pv); end
    en = 1'b1; lk_valid = 1'b1; lk_pc = 64'h100;
    #2 arst = 1'b1;
    m_reset();
    #1;
    n_cmp++; if (pv !== 2'b00 || ptg0 !== 64'h0) begin n_bad++; $display("FAIL arst_async got v=%b t=%h want 00/0", pv, ptg0); end
    @(posedge clk); #1;
    n_cmp++; if (pv !== 2'b00) begin n_bad++; $display("FAIL arst_hold got %b want 00", pv); end
    @(negedge clk);
    arst = 1'b0; lk_valid = 1'b0;
    lk(64'h100);
    n_cmp++; if (pv !== 2'b11 || ph !== 2'b00 || ptg1 !== 64'h104) begin
      n_bad++; $display("FAIL post_arst got v=%b h=%b t=%h want 11/00/104", pv, ph, ptg1); end
  endtask

  task automatic test_random();
    logic [63:0] pool [20];
    pool[0] = 64'hFFFF_FFFF_FFFF_FFFC;
    for (int i = 1; i < 20; i++) pool[i] = {$urandom, $urandom};
    for (int n = 0; n < 600; n++) begin
      cycle(($urandom_range(0, 7) != 0), ($urandom_range(0, 31) == 0), 1'($urandom),
            pool[$urandom_range(0, 19)], 1'($urandom), pool[$urandom_range(0, 19)],
            {$urandom, $urandom}, 1'($urandom), ($urandom_range(0, 5) == 0));
      for (int m = 0; m < 2; m++) begin
        n_cmp++;
        if (pv[m] !== m_pv[m] || ph[m] !== m_ph[m] || pt[m] !== m_pt[m] ||
            (m == 0 ? ptg0 : ptg1) !== m_ptg[m]) begin
          n_bad++;
          $display("FAIL random[%0d] mode%0d got v=%b h=%b tk=%b t=%h want %b/%b/%b/%h", n, m,
                   pv[m], ph[m], pt[m], (m == 0 ? ptg0 : ptg1), m_pv[m], m_ph[m], m_pt[m], m_ptg[m]);
        end
      end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_taken_update();
    test_enable_hold();
    test_counter_sat();
    test_alias();
    test_jump_flush();
    test_gshare();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL have parameter PC_W, default 64, program-counter width.
REQ-002 The block SHALL have parameter ENTRIES, default 64, table depth; power of two, 4..1024.
REQ-003 The block SHALL have parameter TAG_W, default 8, stored tag width; requires IDX_W+2+TAG_W <= PC_W, where IDX_W = log2(ENTRIES).
REQ-004 The block SHALL have parameter MODE, default 0; 0 = bimodal, 1 = gshare.
REQ-005 The block SHALL have parameter HIST_W, default 6, global history width; 1..IDX_W, used only when MODE=1.
REQ-006 The block SHALL have port clk  in  1  sole clock, rising edge.
REQ-007 The block SHALL have port arst  in  1  reset, asynchronous, active-high.
REQ-008 The block SHALL have port en  in  1  global enable; 0 freezes all state and outputs.
REQ-009 The block SHALL have port flush  in  1  synchronous invalidate of all predictor state.
REQ-010 The block SHALL have port lk_valid  in  1  lookup request.
REQ-011 The block SHALL have port lk_pc  in  PC_W  lookup PC.
REQ-012 The block SHALL have port upd_valid  in  1  resolved-branch update.
REQ-013 The block SHALL have port upd_pc  in  PC_W  PC of the resolved branch.
REQ-014 The block SHALL have port upd_target  in  PC_W  resolved target.
REQ-015 The block SHALL have port upd_taken  in  1  resolved direction.
REQ-016 The block SHALL have port upd_jump  in  1  unconditional jump.
REQ-017 The block SHALL have port pred_valid  out  1  prediction valid.
REQ-018 The block SHALL have port pred_hit  out  1  BTB tag hit.
REQ-019 The block SHALL have port pred_taken  out  1  predicted taken.
REQ-020 The block SHALL have port pred_target  out  PC_W  predicted next PC.

Function
REQ-021 The block SHALL index the BTB with idx = pc[IDX_W+1:2] and tag it with pc[IDX_W+TAG_W+1:IDX_W+2].
REQ-022 The block SHALL index the counter table with idx in bimodal mode, and with idx XOR zero-extended ghr in gshare mode.
REQ-023 Each BTB entry SHALL hold: valid, tag, target (PC_W bits), jump flag. Each counter entry SHALL be 2-bit saturating: 00 SNT, 01 WNT, 10 WT, 11 ST.
REQ-024 Lookup latency SHALL be 1 cycle: when lk_valid and en are sampled high, pred_* are registered at that edge and pred_valid=1 for the following cycle.
REQ-025 When lk_valid=0 and en=1, pred_valid SHALL be 0 in the next cycle and the other pred_* outputs SHALL hold.
REQ-026 pred_hit SHALL be 1 when the entry's valid bit is 1 and its tag equals the lookup tag.
REQ-027 pred_taken SHALL equal pred_hit AND (counter[1] OR jump flag).
REQ-028 pred_target SHALL be the stored target when pred_taken=1, else lk_pc+4, modulo 2^PC_W.
REQ-029 On update with upd_taken=1 or upd_jump=1, the BTB entry SHALL be written: valid=1, new tag, upd_target, jump flag=upd_jump. Any aliasing entry SHALL be replaced.
REQ-030 On update with upd_taken=0 and upd_jump=0, the BTB entry SHALL be left unchanged.
REQ-031 On update, the counter SHALL change as follows: upd_jump forces 11; otherwise taken increments, saturating at 11, and not-taken decrements, saturating at 00.
REQ-032 In MODE=1, every update SHALL shift ghr <= {ghr[HIST_W-2:0], upd_taken|upd_jump}; the history is non-speculative. The counter index SHALL use the ghr value from before the shift.
REQ-033 When a lookup and an update hit the same index in the same cycle, the lookup SHALL return the pre-update state (read-before-write).
REQ-034 flush=1 with en=1 SHALL, in one cycle, clear all valid bits, set all counters to 01, clear ghr, and force pred_valid to 0. flush SHALL take priority over a simultaneous update and lookup.
REQ-035 With en=0, no table, ghr or output register SHALL change, regardless of lk_valid, upd_valid or flush.

Reset
REQ-036 When arst asserts, the block SHALL immediately, without waiting for clk: clear all valid bits, set all counters to 01, set ghr to 0, and set pred_valid, pred_hit and pred_taken to 0 and pred_target to 0.
REQ-037 Reset SHALL override en, flush and any in-flight lookup or update. The first lookup after arst deasserts SHALL be served normally.

Verification (PC_W=64, ENTRIES=16, TAG_W=8, MODE=0 unless stated)
REQ-038 Reset, then lookup 0x100 -> next cycle: pred_valid=1, hit=0, taken=0, target=0x104.
REQ-039 Update 0x100 taken, target 0x200, then lookup 0x100 -> hit=1, taken=1 (counter 10), target=0x200.
REQ-040 Two more taken updates (counter 11), then two not-taken updates (counter 01), then lookup 0x100 -> hit=1, taken=0, target=0x104.
REQ-041 Update 0x140 taken, target 0x300 (same idx 0, different tag), then lookup 0x100 -> hit=0; lookup 0x140 -> hit=1, target=0x300.
REQ-042 Jump update 0x80 -> 0x400, then lookup 0x80 -> taken=1, target=0x400. Then flush together with a taken update of 0x80; lookup 0x80 -> hit=0.
REQ-043 Assert arst mid-lookup (lk_valid=1 high) -> pred_valid=0 before the next edge. MODE=1, HIST_W=4: after 4 taken updates, ghr=1111 and 0x100 uses counter index 0xF.
